game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/br_pkg.sv | 32 +++
 rtl/frame_tick_gen.sv | 38 +++
 rtl/game_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/br_pkg.sv
// -----------------------------------------------------------------------------
// br_pkg -- shared definitions for the game sequencer.
//   state_t       : one-hot game state (MENU / PLAY / EXPLODE / OVER); the
//                   encoding doubles as the external status value.
//   KEY_ENTER/ESC : PS/2 make codes that drive state changes.
//   speed_inc_sat : saturating +1 for the 4-bit scroll speed.
// -----------------------------------------------------------------------------
package br_pkg;

  typedef enum logic [3:0] {
    ST_MENU    = 4'b0001,
    ST_PLAY    = 4'b0010,
    ST_EXPLODE = 4'b0100,
    ST_OVER    = 4'b1000
  } state_t;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  // Increment speed by one, but never beyond the ceiling.
  function automatic logic [3:0] speed_inc_sat(input logic [3:0] cur,
                                               input logic [3:0] ceil);
    logic [3:0] res;
    if (cur < ceil) begin
      res = cur + 4'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen -- brings the raw VGA vsync into the clk domain and emits a
// one-cycle frame_tick on its falling edge.
//   clk        : system clock
//   clr        : asynchronous active-low reset
//   vsync      : raw, asynchronous, active-low vertical sync
//   frame_tick : one-cycle pulse, high in the 3rd clk after the vsync fall
// The synchronizer flops and the edge-history flop reset to 1 (vsync idle
// level), so releasing reset never fabricates a falling edge.
// -----------------------------------------------------------------------------
module frame_tick_gen (
  input  logic clk,
  input  logic clr,
  input  logic vsync,
  output logic frame_tick
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= vsync;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Only the fully synchronized stage feeds logic; fall = was 1, now 0.
  assign frame_tick = prev_r & ~sync2_r;

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer -- top-level game flow controller.
// Parameters:
//   EXPLODE_FRAMES    : frame ticks spent in EXPLODE (1..64)
//   BASE_SPEED        : scroll increment at game start (1..15)
//   MAX_SPEED         : speed ceiling (BASE_SPEED..15)
//   SPEED_STEP_FRAMES : PLAY frames per speed increment
// Ports:
//   clk, clr (async active-low reset), vsync (raw, active-low),
//   key_valid/key_code (decoded PS/2 make code), iscollide (obstacle hits),
//   status (one-hot state), btn_visible, explode_visible, explode_frame,
//   scroll (signed, wraps at 2^32), speed, score_tick (one pulse per PLAY frame)
// Build option: define SPEEDUP_EN to ramp speed during PLAY; without it speed
// is fixed at BASE_SPEED and no step counter is built.
// -----------------------------------------------------------------------------
module game_sequencer
  import br_pkg::*;
#(
  parameter int EXPLODE_FRAMES    = 48,
  parameter int BASE_SPEED        = 2,
  parameter int MAX_SPEED         = 8,
  parameter int SPEED_STEP_FRAMES = 600
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               vsync,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  input  logic [4:0]         iscollide,
  output logic [3:0]         status,
  output logic               btn_visible,
  output logic               explode_visible,
  output logic [5:0]         explode_frame,
  output logic signed [31:0] scroll,
  output logic [3:0]         speed,
  output logic               score_tick
);

  // Reject illegal configurations at elaboration time.
  if (EXPLODE_FRAMES < 1 || EXPLODE_FRAMES > 64) begin : g_bad_explode
    $error("EXPLODE_FRAMES must be in 1..64");
  end
  if (BASE_SPEED < 1 || BASE_SPEED > 15) begin : g_bad_base
    $error("BASE_SPEED must be in 1..15");
  end
  if (MAX_SPEED < BASE_SPEED || MAX_SPEED > 15) begin : g_bad_max
    $error("MAX_SPEED must be in BASE_SPEED..15");
  end
  if (SPEED_STEP_FRAMES < 1) begin : g_bad_step
    $error("SPEED_STEP_FRAMES must be at least 1");
  end

  localparam logic [5:0] EXPLODE_LAST = 6'(EXPLODE_FRAMES - 1);
  localparam logic [3:0] BASE_SPD     = 4'(BASE_SPEED);

  logic        frame_tick;
  state_t      state_r;
  logic        btn_visible_r;
  logic        explode_visible_r;
  logic [5:0]  explode_frame_r;
  logic [31:0] scroll_r;
  logic [31:0] scroll_nxt_s;
  logic [3:0]  speed_r;
  logic [3:0]  speed_nxt_s;
  logic        score_tick_r;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .clr        (clr),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  logic key_enter_s;
  logic key_esc_s;
  logic collide_s;
  logic play_tick_s;
  logic play_start_s;

  assign key_enter_s  = key_valid && (key_code == KEY_ENTER);
  assign key_esc_s    = key_valid && (key_code == KEY_ESC);
  assign collide_s    = |iscollide;
  assign play_tick_s  = (state_r == ST_PLAY) && frame_tick;
  assign play_start_s = (state_r == ST_MENU) && key_enter_s;

  // Game FSM with its registered overlay outputs; they switch with the state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r           <= ST_MENU;
      btn_visible_r     <= 1'b1;
      explode_visible_r <= 1'b0;
      explode_frame_r   <= 6'd0;
    end else begin
      case (state_r)
        ST_MENU: begin
          if (key_enter_s) begin
            state_r           <= ST_PLAY;
            btn_visible_r     <= 1'b0;
            explode_visible_r <= 1'b0;
            explode_frame_r   <= 6'd0;
          end else begin
            state_r <= ST_MENU;
          end
        end
        ST_PLAY: begin
          // A colliding frame outranks a simultaneous Esc.
          if (frame_tick && collide_s) begin
            state_r           <= ST_EXPLODE;
            btn_visible_r     <= 1'b0;
            explode_visible_r <= 1'b1;
          end else if (key_esc_s) begin
            state_r           <= ST_MENU;
            btn_visible_r     <= 1'b1;
            explode_visible_r <= 1'b0;
          end else begin
            state_r <= ST_PLAY;
          end
        end
        ST_EXPLODE: begin
          // Keys are ignored here; only frame ticks advance the animation.
          if (frame_tick) begin
            explode_frame_r <= explode_frame_r + 6'd1;
            if (explode_frame_r == EXPLODE_LAST) begin
              state_r           <= ST_OVER;
              btn_visible_r     <= 1'b1;
              explode_visible_r <= 1'b0;
            end else begin
              state_r <= ST_EXPLODE;
            end
          end else begin
            state_r <= ST_EXPLODE;
          end
        end
        ST_OVER: begin
          if (key_enter_s) begin
            state_r           <= ST_MENU;
            btn_visible_r     <= 1'b1;
            explode_visible_r <= 1'b0;
            explode_frame_r   <= 6'd0;
          end else begin
            state_r <= ST_OVER;
          end
        end
        default: begin
          state_r           <= ST_MENU;
          btn_visible_r     <= 1'b1;
          explode_visible_r <= 1'b0;
          explode_frame_r   <= 6'd0;
        end
      endcase
    end
  end

  // Scroll: cleared on game start, advanced by speed on every PLAY frame
  // (plain 32-bit add, so it wraps), held otherwise.
  always_comb begin
    scroll_nxt_s = scroll_r;
    if (play_start_s) begin
      scroll_nxt_s = 32'd0;
    end else if (play_tick_s) begin
      scroll_nxt_s = scroll_r + {28'd0, speed_r};
    end else begin
      scroll_nxt_s = scroll_r;
    end
  end

`ifdef SPEEDUP_EN
  localparam int STEP_W = (SPEED_STEP_FRAMES > 1) ? $clog2(SPEED_STEP_FRAMES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPEED_STEP_FRAMES - 1);
  localparam logic [3:0]        MAX_SPD   = 4'(MAX_SPEED);

  logic [STEP_W-1:0] step_cnt_r;
  logic [STEP_W-1:0] step_cnt_nxt_s;

  // Speed ramp: every SPEED_STEP_FRAMES PLAY frames bump speed and restart.
  always_comb begin
    speed_nxt_s    = speed_r;
    step_cnt_nxt_s = step_cnt_r;
    if (play_start_s) begin
      speed_nxt_s    = BASE_SPD;
      step_cnt_nxt_s = {STEP_W{1'b0}};
    end else if (play_tick_s) begin
      if (step_cnt_r == STEP_LAST) begin
        step_cnt_nxt_s = {STEP_W{1'b0}};
        speed_nxt_s    = speed_inc_sat(speed_r, MAX_SPD);
      end else begin
        step_cnt_nxt_s = step_cnt_r + STEP_W'(1);
        speed_nxt_s    = speed_r;
      end
    end else begin
      speed_nxt_s    = speed_r;
      step_cnt_nxt_s = step_cnt_r;
    end
  end

  // PLAY frame counter register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      step_cnt_r <= {STEP_W{1'b0}};
    end else begin
      step_cnt_r <= step_cnt_nxt_s;
    end
  end
`else
  // Fixed speed build.
  always_comb begin
    speed_nxt_s = BASE_SPD;
  end
`endif

  // Scroll, speed and score pulse registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      scroll_r     <= 32'd0;
      speed_r      <= BASE_SPD;
      score_tick_r <= 1'b0;
    end else begin
      scroll_r     <= scroll_nxt_s;
      speed_r      <= speed_nxt_s;
      score_tick_r <= play_tick_s;
    end
  end

  assign status          = state_r;
  assign btn_visible     = btn_visible_r;
  assign explode_visible = explode_visible_r;
  assign explode_frame   = explode_frame_r;
  assign scroll          = $signed(scroll_r);
  assign speed           = speed_r;
  assign score_tick      = score_tick_r;

endmodule
